// File: rtl/lut_neuron_array.sv
// lut_neuron_array: NUM_NEURONS runtime-writable truth tables evaluated in a
// 2-stage valid/ready pipeline. Tables are loaded through a cfg port once the
// pipeline has drained, so in-flight words always see a consistent table set.

// One neuron lane: table RAM, stage-1 address register, stage-2 result register.
module lut_neuron #(
    parameter int ADDR_W   = 8,
    parameter int OUT_BITS = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                adv,
    input  logic [ADDR_W-1:0]   addr,
    input  logic                we,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [OUT_BITS-1:0] wr_data,
    output logic [OUT_BITS-1:0] dout,
    output logic                loaded
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [OUT_BITS-1:0] ram [DEPTH];
    logic [ADDR_W-1:0]   addr_q;

    // Table write port; contents survive reset, the loaded flag masks them instead.
    always_ff @(posedge clk) begin
        if (we) ram[wr_addr] <= wr_data;
    end

    // Stage 1 captures the address, stage 2 reads the table; both move only on adv.
    always_ff @(posedge clk) begin
        if (!rst) begin
            addr_q <= '0;
            dout   <= '0;
            loaded <= 1'b0;
        end else begin
            if (we) loaded <= 1'b1;
            if (adv) begin
                addr_q <= addr;
                dout   <= loaded ? ram[addr_q] : '0;
            end
        end
    end
endmodule

module lut_neuron_array #(
    parameter int NUM_NEURONS  = 4,
    parameter int IN_BITS      = 2,
    parameter int FAN_IN       = 4,
    parameter int OUT_BITS     = 2,
    parameter int NEURON_IDX_W = 2
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         in_valid,
    output logic                                         in_ready,
    input  logic [NUM_NEURONS*IN_BITS*FAN_IN-1:0]        in_data,
    output logic                                         out_valid,
    input  logic                                         out_ready,
    output logic [NUM_NEURONS*OUT_BITS-1:0]              out_data,
    input  logic                                         cfg_req,
    output logic                                         cfg_ack,
    input  logic                                         cfg_we,
    input  logic [NEURON_IDX_W-1:0]                      cfg_neuron,
    input  logic [IN_BITS*FAN_IN-1:0]                    cfg_addr,
    input  logic [OUT_BITS-1:0]                          cfg_data,
    output logic [NUM_NEURONS-1:0]                       tbl_loaded
);
    localparam int ADDR_W = IN_BITS * FAN_IN;

    typedef enum logic [1:0] {
        st_run   = 2'd0,
        st_drain = 2'd1,
        st_load  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [2:1]                               vld_pipe;
    logic                                     adv;
    logic                                     acc;
    logic                                     wr_en;
    logic [NUM_NEURONS-1:0][ADDR_W-1:0]       lane_addr;
    logic [NUM_NEURONS-1:0][OUT_BITS-1:0]     lane_out;

    assign adv       = !vld_pipe[2] || out_ready;
    assign in_ready  = (state_q == st_run) && adv && !cfg_req;
    assign acc       = in_valid && in_ready;
    assign out_valid = vld_pipe[2];
    assign cfg_ack   = (state_q == st_load);
    assign wr_en     = rst && (state_q == st_load) && cfg_we;
    assign lane_addr = in_data;
    assign out_data  = lane_out;

    // Mode register.
    always_ff @(posedge clk) begin
        if (!rst) state_q <= st_run;
        else      state_q <= state_d;
    end

    // Mode transitions: block input, wait for the pipe to empty, then allow writes.
    always_comb begin
        state_d = state_q;
        case (state_q)
            st_run:   if (cfg_req) state_d = st_drain;
            st_drain: if (!vld_pipe[1] && !vld_pipe[2]) state_d = st_load;
            st_load:  if (!cfg_req) state_d = st_run;
            default:  state_d = st_run;
        endcase
    end

    // Stage valid bits shift together with the data registers in each lane.
    always_ff @(posedge clk) begin
        if (!rst)     vld_pipe <= '0;
        else if (adv) vld_pipe <= {vld_pipe[1], acc};
    end

    // Out-of-range cfg_neuron values match no lane, so such writes fall away.
    for (genvar n = 0; n < NUM_NEURONS; n++) begin : g_lane
        lut_neuron #(
            .ADDR_W   (ADDR_W),
            .OUT_BITS (OUT_BITS)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .adv     (adv),
            .addr    (lane_addr[n]),
            .we      (wr_en && (cfg_neuron == NEURON_IDX_W'(n))),
            .wr_addr (cfg_addr),
            .wr_data (cfg_data),
            .dout    (lane_out[n]),
            .loaded  (tbl_loaded[n])
        );
    end
endmodule
